// File: rtl/afifo_write_arbiter.sv
// Round-robin write-port arbiter for the AFIFO: grants one requester per burst
// and tags each written word with the requester ID in the upper bits of wd.
//
// state | meaning
// IDLE  | no grant held; arbitrate among valid requesters (1 cycle, no writes)
// BURST | grant_id owns the write port until last, MaxBurst beats or idle timeout
module afifo_write_arbiter #(
   parameter int NReq        = 4,
   parameter int DataW       = 10,
   parameter int MaxBurst    = 8,
   parameter int IdleTimeout = 4,
   localparam int IdW        = $clog2(NReq),
   localparam int Width      = DataW + IdW
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NReq-1:0]         req_valid,
   input  logic [NReq*DataW-1:0]   req_data,
   input  logic [NReq-1:0]         req_last,
   output logic [NReq-1:0]         req_ready,
   output logic                    w,
   output logic [Width-1:0]        wd,
   input  logic                    wfull,
   output logic [IdW-1:0]          grant_id,
   output logic                    busy
);

   localparam int BeatW = $clog2(MaxBurst + 1);
   localparam int IdleW = $clog2(IdleTimeout + 1);
   localparam logic [BeatW-1:0] BeatMax = BeatW'(MaxBurst);
   localparam logic [IdleW-1:0] IdleMax = IdleW'(IdleTimeout);

   typedef enum logic {
      S_IDLE,
      S_BURST
   } state_t;

   state_t           state_q, state_d;
   logic [IdW-1:0]   grant_q, grant_d;
   logic [IdW-1:0]   ptr_q, ptr_d;
   logic [BeatW-1:0] beat_q, beat_d, beat_inc;
   logic [IdleW-1:0] idle_q, idle_d, idle_inc;

   logic             pick_found;
   logic [IdW-1:0]   pick_id;
   logic [IdW-1:0]   cand;
   logic             g_valid;
   logic             g_last;
   logic [DataW-1:0] g_data;
   logic             accept;

   // Scan upward from the slot after the last winner; i == NReq wraps back to ptr_q itself.
   always_comb begin
      pick_found = 1'b0;
      pick_id    = '0;
      cand       = '0;
      for (int i = 1; i <= NReq; i++) begin
         cand = ptr_q + IdW'(i);
         if (!pick_found && req_valid[cand]) begin
            pick_found = 1'b1;
            pick_id    = cand;
         end
      end
   end

   assign g_valid  = req_valid[grant_q];
   assign g_last   = req_last[grant_q];
   assign g_data   = req_data[grant_q*DataW +: DataW];
   assign accept   = (state_q == S_BURST) && g_valid && !wfull && !rst;
   assign beat_inc = beat_q + BeatW'(1);
   assign idle_inc = idle_q + IdleW'(1);

   assign w        = accept;
   assign wd       = rst ? '0 : {grant_q, g_data};
   assign grant_id = grant_q;
   assign busy     = (state_q == S_BURST);

   always_comb begin
      req_ready = '0;
      if (accept) begin
         req_ready[grant_q] = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      beat_d  = beat_q;
      idle_d  = idle_q;
      case (state_q)
         S_IDLE: begin
            if (pick_found) begin
               state_d = S_BURST;
               grant_d = pick_id;
               beat_d  = '0;
               idle_d  = '0;
            end
         end
         S_BURST: begin
            if (accept) begin
               beat_d = beat_inc;
               idle_d = '0;
               if (g_last || (beat_inc == BeatMax)) begin
                  state_d = S_IDLE;
                  ptr_d   = grant_q;
               end
            end else if (!g_valid) begin
               // A full-stalled cycle with valid high leaves both counters untouched.
               idle_d = idle_inc;
               if (idle_inc == IdleMax) begin
                  state_d = S_IDLE;
                  ptr_d   = grant_q;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         ptr_q   <= IdW'(NReq - 1);
         beat_q  <= '0;
         idle_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         beat_q  <= beat_d;
         idle_q  <= idle_d;
      end
   end

endmodule

// File: tb/tb_afifo_write_arbiter.sv
// Bench for afifo_write_arbiter: source queues model the requesters, a negedge
// monitor checks every written word against a hand-ordered expected queue.
module tb_afifo_write_arbiter;

   localparam int NReq  = 4;
   localparam int DataW = 10;
   localparam int Width = 12;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NReq-1:0]       req_valid;
   logic [NReq*DataW-1:0] req_data;
   logic [NReq-1:0]       req_last;
   logic [NReq-1:0]       req_ready;
   logic                  w;
   logic [Width-1:0]      wd;
   logic                  wfull;
   logic [1:0]            grant_id;
   logic                  busy;

   always #5 clk = ~clk;

   afifo_write_arbiter #(
      .NReq(4), .DataW(10), .MaxBurst(8), .IdleTimeout(4)
   ) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_last(req_last), .req_ready(req_ready), .w(w), .wd(wd),
      .wfull(wfull), .grant_id(grant_id), .busy(busy)
   );

   int total = 0;
   int bad   = 0;
   logic [DataW:0]   src_q [NReq][$];
   logic [Width-1:0] exp_q [$];
   logic [NReq-1:0]  en;
   logic [NReq-1:0]  rdy;
   int acc_cnt [NReq];
   int cyc_n = 0;
   int first_wr = -1;
   int last_wr  = -1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_n);
      end
   endtask

   function automatic logic [DataW-1:0] dat(input int r, input int k);
      return DataW'(r * 64 + k);
   endfunction

   task automatic load(input int r, input int n, input int lastn);
      for (int k = 0; k < n; k++) begin
         src_q[r].push_back({(lastn > 0 && (k + 1) % lastn == 0), dat(r, k)});
      end
   endtask

   task automatic exp_w(input int r, input int k);
      exp_q.push_back({2'(r), dat(r, k)});
   endtask

   function automatic int pending();
      int s = 0;
      for (int i = 0; i < NReq; i++) s += src_q[i].size();
      return s;
   endfunction

   task automatic drive();
      for (int i = 0; i < NReq; i++) begin
         if (src_q[i].size() > 0) begin
            req_valid[i]               = en[i];
            req_data[i*DataW +: DataW] = src_q[i][0][DataW-1:0];
            req_last[i]                = src_q[i][0][DataW];
         end else begin
            req_valid[i]               = 1'b0;
            req_data[i*DataW +: DataW] = '0;
            req_last[i]                = 1'b0;
         end
      end
   endtask

   // Finishes a cycle from its negedge: capture handshakes, cross the edge, re-drive.
   task automatic tail();
      rdy = req_ready;
      @(posedge clk);
      #1;
      cyc_n++;
      for (int i = 0; i < NReq; i++) begin
         if (rdy[i]) begin
            if (src_q[i].size() > 0) void'(src_q[i].pop_front());
            acc_cnt[i]++;
         end
      end
      drive();
   endtask

   task automatic cycle();
      @(negedge clk);
      tail();
   endtask

   task automatic run_until_done(input string name);
      int n = 0;
      while ((pending() > 0 || exp_q.size() > 0 || busy !== 1'b0) && n < 300) begin
         cycle();
         n++;
      end
      chk({name, "_finished"}, n < 300, 1);
   endtask

   task automatic wait_acc(input int r, input int cnt);
      int n = 0;
      while (acc_cnt[r] < cnt && n < 60) begin
         cycle();
         n++;
      end
      chk("wait_accept", acc_cnt[r] >= cnt, 1);
   endtask

   task automatic clear_acc();
      for (int i = 0; i < NReq; i++) acc_cnt[i] = 0;
   endtask

   always @(negedge clk) begin
      if (w === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: got wd=%0h expected no write (cycle %0d)", wd, cyc_n);
         end else begin
            chk("wd", wd, exp_q.pop_front());
         end
         if (first_wr < 0) first_wr = cyc_n;
         last_wr = cyc_n;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      wfull     = 1'b0;
      en        = '1;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      clear_acc();

      @(negedge clk);
      chk("rst_w", w, 0);
      chk("rst_wd", wd, 0);
      chk("rst_ready", req_ready, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_grant", grant_id, 0);
      tail();

      // 1: requesters 0 and 2, last every 3rd word
      first_wr = -1;
      load(0, 6, 3);
      load(2, 6, 3);
      for (int k = 0; k < 3; k++) exp_w(0, k);
      for (int k = 0; k < 3; k++) exp_w(2, k);
      for (int k = 3; k < 6; k++) exp_w(0, k);
      for (int k = 3; k < 6; k++) exp_w(2, k);
      drive();
      run_until_done("t1");
      chk("t1_span", last_wr - first_wr, 14);

      // 2: requester 1 streams 20 words, no last -> 8, 8, 4
      first_wr = -1;
      load(1, 20, 0);
      for (int k = 0; k < 20; k++) exp_w(1, k);
      drive();
      run_until_done("t2");
      chk("t2_span", last_wr - first_wr, 21);

      // 3: wfull held 10 cycles mid-burst of requester 3
      clear_acc();
      load(3, 6, 6);
      for (int k = 0; k < 6; k++) exp_w(3, k);
      drive();
      wait_acc(3, 2);
      wfull = 1'b1;
      repeat (10) begin
         @(negedge clk);
         chk("t3_full_w", w, 0);
         chk("t3_full_ready", req_ready, 0);
         chk("t3_full_grant", grant_id, 3);
         chk("t3_full_busy", busy, 1);
         tail();
      end
      wfull = 1'b0;
      @(negedge clk);
      chk("t3_resume_w", w, 1);
      chk("t3_resume_wd", wd, {2'd3, dat(3, 2)});
      tail();
      run_until_done("t3");

      // 4: requester 2 stalls after 2 words -> idle timeout, then 3 wins
      clear_acc();
      load(2, 4, 4);
      load(3, 3, 3);
      exp_w(2, 0); exp_w(2, 1);
      exp_w(3, 0); exp_w(3, 1); exp_w(3, 2);
      exp_w(2, 2); exp_w(2, 3);
      drive();
      wait_acc(2, 2);
      en[2] = 1'b0;
      drive();
      repeat (4) begin
         @(negedge clk);
         chk("t4_idle_busy", busy, 1);
         chk("t4_idle_w", w, 0);
         tail();
      end
      en[2] = 1'b1;
      drive();
      @(negedge clk);
      chk("t4_arb_busy", busy, 0);
      tail();
      @(negedge clk);
      chk("t4_next_busy", busy, 1);
      chk("t4_next_grant", grant_id, 3);
      tail();
      run_until_done("t4");

      // 5: fresh reset, all four valid with last on every word
      rst = 1'b1;
      @(negedge clk);
      chk("t5_rst_w", w, 0);
      tail();
      rst = 1'b0;
      clear_acc();
      first_wr = -1;
      for (int r = 0; r < NReq; r++) load(r, 4, 1);
      for (int k = 0; k < 4; k++)
         for (int r = 0; r < NReq; r++) exp_w(r, k);
      drive();
      run_until_done("t5");
      chk("t5_span", last_wr - first_wr, 30);
      for (int r = 0; r < NReq; r++) chk("t5_share", acc_cnt[r], 4);

      // 6: reset mid-burst of requester 1 with everyone valid
      clear_acc();
      load(1, 6, 6);
      exp_w(1, 0); exp_w(1, 1);
      exp_w(0, 0);
      for (int k = 2; k < 6; k++) exp_w(1, k);
      exp_w(2, 0); exp_w(3, 0);
      drive();
      wait_acc(1, 2);
      load(0, 1, 1);
      load(2, 1, 1);
      load(3, 1, 1);
      rst = 1'b1;
      drive();
      @(negedge clk);
      chk("t6_rst_w", w, 0);
      chk("t6_rst_ready", req_ready, 0);
      chk("t6_rst_wd", wd, 0);
      tail();
      rst = 1'b0;
      @(negedge clk);
      chk("t6_arb_busy", busy, 0);
      chk("t6_arb_w", w, 0);
      tail();
      @(negedge clk);
      chk("t6_grant", grant_id, 0);
      chk("t6_busy", busy, 1);
      tail();
      run_until_done("t6");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/afifo_write_arbiter.md
Name: afifo_write_arbiter

Overview:
Shares the single write port of the AFIFO between NReq requesters in the write-clock domain. Uses round-robin arbitration with burst-granular grants. Each accepted word is tagged with the requester ID in the upper bits of wd, so the read side can demultiplex. The block sits entirely in the wclk domain and drives AFIFO w/wd from its wfull.

Parameters:
NReq, 4, number of requesters (power of 2, >=2)
IdW, $clog2(NReq), width of the requester ID tag (derived; not overridable)
DataW, 10, payload width per requester
Width, DataW+IdW (12 at defaults), FIFO word width; must equal the AFIFO Width
MaxBurst, 8, max words per grant before forced rotation (>=1)
IdleTimeout, 4, consecutive no-valid cycles in BURST before grant is released (>=1)

Ports:
clk  in  1  write-side clock (same clock as AFIFO wclk)
rst  in  1  synchronous, active-high reset
req_valid  in  NReq  requester i has a word on its slice of req_data
req_data  in  NReq*DataW  payloads; requester i occupies bits [i*DataW +: DataW]
req_last  in  NReq  the current word ends requester i's burst
req_ready  out  NReq  requester i's word is accepted this cycle
w  out  1  AFIFO write strobe
wd  out  Width  AFIFO write data = {grant_id, req_data slice}
wfull  in  1  AFIFO full flag
grant_id  out  IdW  currently granted requester (valid when busy)
busy  out  1  FSM is in BURST

Behaviour:
- Reset (sync, rst high at posedge clk):
  - state=IDLE, grant_id=0, busy=0, beat count=0, idle count=0.
  - Round-robin pointer=NReq-1, so requester 0 has top priority after reset.
  - w, req_ready and wd are 0 in the same cycle rst is high (combinational gating on rst).
- IDLE:
  - If any req_valid is high, select the first valid requester scanning upward from pointer+1, mod NReq.
  - Register it into grant_id, go to BURST, clear beat count and idle count.
  - No words are accepted in IDLE. Arbitration costs exactly 1 cycle.
- BURST:
  - w = req_valid[grant_id] & !wfull.
  - req_ready[grant_id] = w; all other req_ready bits are 0.
  - wd = {grant_id, data of grant_id}. wd is don't-care when w=0 but must not be X after reset.
  - Accepted beat (w=1): beat count++, idle count cleared.
  - Cycle with req_valid[grant_id]=0: idle count++. Cycle stalled by wfull with valid high: idle count unchanged, beat count unchanged.
  - Exit to IDLE at the clock edge where any of these holds:
    - accepted beat has req_last=1;
    - accepted beat brings beat count to MaxBurst;
    - idle count reaches IdleTimeout.
  - On exit, pointer := grant_id.
- wfull:
  - wfull is never bypassed. While wfull=1, w=0 and the grant is held indefinitely; there is no timeout on full.
- Latency and throughput:
  - Request seen in IDLE -> first write 1 cycle later when not full.
  - Back-to-back bursts cost 1 idle arbitration cycle between them.
- Simultaneous events:
  - last and MaxBurst on the same beat: a single exit.
  - New requests during BURST: only sampled at the next IDLE.
  - Granted requester deasserting valid mid-burst is legal.
- Reset mid-BURST:
  - Any in-flight word not accepted is dropped.
  - Pointer resets to NReq-1.
  - The AFIFO is not reset by this block.
- Widths:
  - Beat count is $clog2(MaxBurst+1) bits and idle count is $clog2(IdleTimeout+1) bits; neither wraps, because exit happens at terminal value.

Test Plan:
1. Reset, then req_valid=4'b0101 held, words from both requesters with last on the 3rd word -> wd tags sequence 0,0,0,(idle),2,2,2,(idle),0…; grant_id alternates 0/2; 1-cycle gap between bursts.
2. Requester 1 streams 20 words with last never set, MaxBurst=8, other requesters idle -> bursts of 8, 8, 4+… (re-granted to 1 after each 1-cycle IDLE); no word lost or duplicated, and the payload sequence is intact.
3. wfull forced high for 10 cycles mid-burst of requester 3 -> w=0 and req_ready=0 throughout; grant_id stays 3 and busy stays 1; resumes on the first cycle wfull=0 with the same data.
4. Requester 2 granted, then drops req_valid after 2 words with IdleTimeout=4 -> exits to IDLE after exactly 4 no-valid cycles; requester 3 (valid) is granted next, not 2.
5. All 4 requesters valid continuously with last on every word -> grants rotate 0,1,2,3,0…; every requester receives an equal share over 16 words.
6. rst asserted for 1 cycle mid-burst of requester 1, with all requesters valid -> w=0 in that cycle; next grant goes to requester 0.
